inverse_clarke_transform: RTL and testbench

INVERSE_CLARKE_TRANSFORM -- requirements
Module: inverse_clarke_transform

---
 rtl/fixed_point_pkg.sv | 8 +
 rtl/q15_saturate.sv | 34 +++
 rtl/inverse_clarke_transform.sv | 127 ++++++++++++
 tb/tb_inverse_clarke_transform.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared Q15 fixed-point constants for the motor-control datapath.
package fixed_point_pkg;

   localparam int Q15_SQRT3_DIV2 = 28378;
   localparam int Q15_MAX        = 32767;
   localparam int Q15_MIN        = -32768;

endpackage

// File: rtl/q15_saturate.sv
// Narrows a wide signed result to OUT_W bits.
// INVERSE_CLARKE_SAT_EN selects clamping; otherwise two's-complement wrap.
module q15_saturate
   import fixed_point_pkg::*;
#(
   parameter int unsigned IN_W  = 18,
   parameter int unsigned OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] sat_c
);

`ifdef INVERSE_CLARKE_SAT_EN
   // Q15 bounds for the native width, generic bounds for any other width
   localparam logic signed [IN_W-1:0] MAX_V = (OUT_W == 16) ? IN_W'(Q15_MAX)
                                              : (IN_W'(1) << (OUT_W - 1)) - IN_W'(1);
   localparam logic signed [IN_W-1:0] MIN_V = (OUT_W == 16) ? IN_W'(Q15_MIN) : ~MAX_V;

   always_comb begin
      sat_c = din[OUT_W-1:0];
      if (din > MAX_V) begin
         sat_c = MAX_V[OUT_W-1:0];
      end else if (din < MIN_V) begin
         sat_c = MIN_V[OUT_W-1:0];
      end
   end
`else
   logic unused_hi;

   assign unused_hi = ^din[IN_W-1:OUT_W];
   assign sat_c     = din[OUT_W-1:0];
`endif

endmodule

// File: rtl/inverse_clarke_transform.sv
// Three-stage inverse Clarke transform {beta, alpha} -> {w, v, u} with valid/ready.
// Define INVERSE_CLARKE_SAT_EN to clamp v/w instead of wrapping them.
module inverse_clarke_transform
   import fixed_point_pkg::*;
#(
   parameter int unsigned CHANNEL_WIDTH = 1,
   parameter int unsigned DATA_WIDTH    = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [2*DATA_WIDTH-1:0]    in_data,
   input  logic [CHANNEL_WIDTH-1:0]   in_channel,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [3*DATA_WIDTH-1:0]    out_data,
   output logic [CHANNEL_WIDTH-1:0]   out_channel,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam int unsigned DW = DATA_WIDTH;
   localparam int unsigned SW = DATA_WIDTH + 2;
   localparam int unsigned KW = 17;
   localparam int unsigned PW = DATA_WIDTH + KW;

   localparam logic signed [KW-1:0] K_C   = KW'(Q15_SQRT3_DIV2);
   localparam logic signed [PW-1:0] RND_C = PW'(16384);

   logic                      en_c;
   logic signed [PW-1:0]      prod_c, rnd_c;
   logic signed [SW-1:0]      vfull_c, wfull_c;
   logic signed [DW-1:0]      vsat_c, wsat_c;

   logic                      vld1_q, vld1_d, vld2_q, vld2_d, vld3_q, vld3_d;
   logic signed [DW-1:0]      alpha1_q, alpha1_d, beta1_q, beta1_d;
   logic signed [DW-1:0]      u2_q, u2_d;
   logic signed [SW-1:0]      s2_q, s2_d, h2_q, h2_d;
   logic signed [DW-1:0]      u3_q, u3_d, v3_q, v3_d, w3_q, w3_d;
   logic [CHANNEL_WIDTH-1:0]  ch1_q, ch1_d, ch2_q, ch2_d, ch3_q, ch3_d;

   // S3 narrowing of the wide v/w differences
   q15_saturate #(.IN_W(SW), .OUT_W(DW)) u_sat_v (.din(vfull_c), .sat_c(vsat_c));
   q15_saturate #(.IN_W(SW), .OUT_W(DW)) u_sat_w (.din(wfull_c), .sat_c(wsat_c));

   // Whole pipe advances as one unit whenever the output slot can move
   always_comb begin
      en_c    = out_ready | ~vld3_q;
      prod_c  = PW'(beta1_q) * PW'(K_C);
      rnd_c   = prod_c + RND_C;
      vfull_c = s2_q - h2_q;
      wfull_c = -h2_q - s2_q;

      vld1_d   = vld1_q;
      alpha1_d = alpha1_q;
      beta1_d  = beta1_q;
      ch1_d    = ch1_q;
      vld2_d   = vld2_q;
      u2_d     = u2_q;
      s2_d     = s2_q;
      h2_d     = h2_q;
      ch2_d    = ch2_q;
      vld3_d   = vld3_q;
      u3_d     = u3_q;
      v3_d     = v3_q;
      w3_d     = w3_q;
      ch3_d    = ch3_q;

      if (en_c) begin
         vld1_d   = in_valid;
         alpha1_d = in_data[DW-1:0];
         beta1_d  = in_data[2*DW-1:DW];
         ch1_d    = in_channel;

         vld2_d   = vld1_q;
         u2_d     = alpha1_q;
         s2_d     = SW'(rnd_c >>> 15);
         h2_d     = SW'(alpha1_q >>> 1);
         ch2_d    = ch1_q;

         vld3_d   = vld2_q;
         u3_d     = u2_q;
         v3_d     = vsat_c;
         w3_d     = wsat_c;
         ch3_d    = ch2_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld1_q   <= 1'b0;
         alpha1_q <= '0;
         beta1_q  <= '0;
         ch1_q    <= '0;
         vld2_q   <= 1'b0;
         u2_q     <= '0;
         s2_q     <= '0;
         h2_q     <= '0;
         ch2_q    <= '0;
         vld3_q   <= 1'b0;
         u3_q     <= '0;
         v3_q     <= '0;
         w3_q     <= '0;
         ch3_q    <= '0;
      end else begin
         vld1_q   <= vld1_d;
         alpha1_q <= alpha1_d;
         beta1_q  <= beta1_d;
         ch1_q    <= ch1_d;
         vld2_q   <= vld2_d;
         u2_q     <= u2_d;
         s2_q     <= s2_d;
         h2_q     <= h2_d;
         ch2_q    <= ch2_d;
         vld3_q   <= vld3_d;
         u3_q     <= u3_d;
         v3_q     <= v3_d;
         w3_q     <= w3_d;
         ch3_q    <= ch3_d;
      end
   end

   assign in_ready    = en_c;
   assign out_valid   = vld3_q;
   assign out_data    = {w3_q, v3_q, u3_q};
   assign out_channel = ch3_q;

endmodule

// File: tb/tb_inverse_clarke_transform.sv
// Scoreboard bench for inverse_clarke_transform: directed vectors, latency,
// back-to-back, stall, circular sweep with random backpressure, reset mid-stream.
module tb_inverse_clarke_transform;

   localparam int unsigned DW = 16;
   localparam int unsigned CW = 2;

   typedef struct packed {
      logic          nosat;
      logic [CW-1:0] ch;
      logic [47:0]   data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [31:0]   in_data;
   logic [CW-1:0] in_channel;
   logic          in_valid;
   logic          in_ready;
   logic [47:0]   out_data;
   logic [CW-1:0] out_channel;
   logic          out_valid;
   logic          out_ready;

   exp_t sb[$];
   int   checks    = 0;
   int   passes    = 0;
   int   out_count = 0;
   int   cyc       = 0;
   bit   rand_ready = 1'b0;

   inverse_clarke_transform #(.CHANNEL_WIDTH(CW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_data(in_data), .in_channel(in_channel), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_channel(out_channel), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   function automatic exp_t mk(input int u, input int v, input int w, input logic [CW-1:0] ch,
                               input bit nosat);
      exp_t e;
      e.nosat = nosat;
      e.ch    = ch;
      e.data  = {w[15:0], v[15:0], u[15:0]};
      return e;
   endfunction

   function automatic exp_t model(input int a, input int b, input logic [CW-1:0] ch);
      longint s, h, v, w;
      bit     ns;
      s  = ((longint'(b) * 28378) + 16384) >>> 15;
      h  = longint'(a) >>> 1;
      v  = s - h;
      w  = -h - s;
      ns = (v <= 32767) && (v >= -32768) && (w <= 32767) && (w >= -32768);
`ifdef INVERSE_CLARKE_SAT_EN
      if (v > 32767) v = 32767; else if (v < -32768) v = -32768;
      if (w > 32767) w = 32767; else if (w < -32768) w = -32768;
`endif
      return mk(a, int'(v), int'(w), ch, ns);
   endfunction

   // Output monitor: pops the scoreboard on every transfer and checks hold under stall
   logic [47:0]   prev_data;
   logic [CW-1:0] prev_ch;
   bit            prev_stall = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      logic signed [15:0] fu, fv, fw;
      int sum;
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_channel !== prev_ch)
               $display("FAIL stall_hold: valid=%b data=%h ch=%h, required valid=1 data=%h ch=%h",
                        out_valid, out_data, out_channel, prev_data, prev_ch);
            else passes++;
         end
         prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
         prev_data  = out_data;
         prev_ch    = out_channel;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            out_count++;
            checks++;
            if (sb.size() == 0) begin
               $display("FAIL unexpected_beat: data=%h ch=%h with nothing outstanding",
                        out_data, out_channel);
            end else begin
               e = sb.pop_front();
               if (out_data !== e.data || out_channel !== e.ch)
                  $display("FAIL beat_data: got data=%h ch=%h, required data=%h ch=%h",
                           out_data, out_channel, e.data, e.ch);
               else passes++;
               if (e.nosat) begin
                  fu  = out_data[15:0];
                  fv  = out_data[31:16];
                  fw  = out_data[47:32];
                  sum = int'(fu) + int'(fv) + int'(fw);
                  checks++;
                  if (sum > 2 || sum < -2)
                     $display("FAIL phase_sum: u+v+w=%0d, required |sum|<=2", sum);
                  else passes++;
               end
            end
         end
      end
   end

   task automatic send(input int a, input int b, input logic [CW-1:0] ch, input exp_t e);
      int g = 0;
      in_valid   = 1'b1;
      in_data    = {b[15:0], a[15:0]};
      in_channel = ch;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            sb.push_back(e);
            @(posedge clk);
            #1;
            break;
         end
         @(posedge clk);
         #1;
         g++;
         if (g > 200) begin
            checks++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, g);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && g < 200) begin
         @(posedge clk);
         g++;
      end
      #1;
      checks++;
      if (sb.size() != 0) $display("FAIL drain: %0d beats outstanding, required 0", sb.size());
      else passes++;
   endtask

   task automatic test_reset();
      reset_n    = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      in_channel = '0;
      out_ready  = 1'b0;
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 48'h0 || out_channel !== '0)
         $display("FAIL reset_outputs: valid=%b data=%h ch=%h, required all 0",
                  out_valid, out_data, out_channel);
      else passes++;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: %b, required 1", in_ready);
      else passes++;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL post_reset: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
      else passes++;
   endtask

   task automatic test_directed();
      out_ready = 1'b1;
      send(0, 0, 2'd0, mk(0, 0, 0, 2'd0, 1'b1));
      send(20000, 0, 2'd1, mk(20000, -10000, -10000, 2'd1, 1'b1));
      send(0, 10000, 2'd2, mk(0, 8660, -8660, 2'd2, 1'b1));
`ifdef INVERSE_CLARKE_SAT_EN
      send(-32768, 32767, 2'd3, mk(-32768, 32767, -11993, 2'd3, 1'b0));
`else
      send(-32768, 32767, 2'd3, mk(-32768, -20775, -11993, 2'd3, 1'b0));
`endif
      drain();
   endtask

   task automatic test_latency();
      int c0, lat;
      out_ready = 1'b1;
      c0  = cyc;
      lat = -1;
      send(1000, -2000, 2'd1, model(1000, -2000, 2'd1));
      for (int k = 0; k < 10; k++) begin
         if (out_valid === 1'b1) begin
            lat = cyc - c0;
            break;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (lat != 3) $display("FAIL latency: %0d cycles, required 3", lat);
      else passes++;
      drain();
   endtask

   task automatic test_back_to_back();
      int c0;
      out_ready = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 8; i++)
         send(i * 3000 - 12000, 7000 - i * 1500, CW'(i), model(i * 3000 - 12000, 7000 - i * 1500, CW'(i)));
      checks++;
      if (cyc - c0 != 8) $display("FAIL throughput: 8 beats took %0d cycles, required 8", cyc - c0);
      else passes++;
      drain();
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      send(-5000, 3000, 2'd2, model(-5000, 3000, 2'd2));
      send(12345, -23456, 2'd3, model(12345, -23456, 2'd3));
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL stall_ready: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
      else passes++;
      in_valid   = 1'b1;
      in_data    = {16'd100, 16'd200};
      in_channel = 2'd1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(200, 100, 2'd1, model(200, 100, 2'd1));
      drain();
   endtask

   task automatic test_sweep();
      int  o0, a, b;
      real th;
      o0 = out_count;
      rand_ready = 1'b1;
      for (int i = 0; i < 512; i++) begin
         th = 6.283185307179586 * real'(i) / 512.0;
         a  = $rtoi(32767.0 * $cos(th));
         b  = $rtoi(32767.0 * $sin(th));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send(a, b, CW'(i), model(a, b, CW'(i)));
      end
      rand_ready = 1'b0;
      drain();
      checks++;
      if (out_count - o0 != 512) $display("FAIL sweep_count: %0d outputs, required 512", out_count - o0);
      else passes++;
   endtask

   task automatic test_reset_in_flight();
      int stale = 0;
      out_ready = 1'b0;
      send(1111, 2222, 2'd1, model(1111, 2222, 2'd1));
      send(-3333, 4444, 2'd2, model(-3333, 4444, 2'd2));
      send(5555, -6666, 2'd3, model(5555, -6666, 2'd3));
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 48'h0 || out_channel !== '0 || in_ready !== 1'b1)
         $display("FAIL reset_async: valid=%b data=%h ch=%h in_ready=%b, required 0/0/0/1",
                  out_valid, out_data, out_channel, in_ready);
      else passes++;
      sb.delete();
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) stale++;
      end
      checks++;
      if (stale != 0) $display("FAIL stale_after_reset: %0d valid cycles, required 0", stale);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_latency();
      test_back_to_back();
      test_stall();
      test_sweep();
      test_reset_in_flight();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
